// File: rtl/tacc_heater_pkg.sv
// tacc_heater_pkg: opcodes, response codes, frame length and FSM states for the heater command decoder
package tacc_heater_pkg;
  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_STOP = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] RSP_START = 8'hA1;
  localparam logic [7:0] RSP_STOP = 8'hA2;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [2:0] FRAME_LEN = 3'd5;
  typedef enum logic [1:0] {RX, GAP, EXEC, RESP} state_t;
endpackage

// File: rtl/tacc_heater_cmd_if.sv
// tacc_heater_cmd_if: pseudo-UART receive/transmit byte interface
interface tacc_heater_cmd_if;
  logic from_uart_ready;
  logic from_uart_read_en;
  logic [7:0] from_uart_data;
  logic to_uart_ready;
  logic to_uart_write_en;
  logic [7:0] to_uart_data;
  modport master (
    output from_uart_ready, from_uart_data, to_uart_ready,
    input from_uart_read_en, to_uart_write_en, to_uart_data
  );
  modport slave (
    input from_uart_ready, from_uart_data, to_uart_ready,
    output from_uart_read_en, to_uart_write_en, to_uart_data
  );
endinterface

// File: rtl/tacc_heater_timer.sv
// tacc_heater_timer: loadable down-counter driving the heater enable and expiry pulse
module tacc_heater_timer #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic clear,
  input logic [CNT_W-1:0] arg,
  output logic heater_en,
  output logic heater_done
);
  logic [CNT_W-1:0] count;
  assign heater_en = count != '0;
  // a reload or clear in the expiring cycle suppresses the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      heater_done <= 1'b0;
    end else begin
      count <= load ? arg : clear ? '0 : heater_en ? count - CNT_W'(1) : count;
      heater_done <= count == CNT_W'(1) && !load && !clear;
    end
  end
endmodule

// File: rtl/tacc_heater_cmd.sv
// tacc_heater_cmd: assembles 5-byte host frames, runs the heater timer and returns a one-byte response
module tacc_heater_cmd
  import tacc_heater_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  tacc_heater_cmd_if.slave bus,
  output logic heater_en,
  output logic heater_done,
  output logic [7:0] frame_err_cnt
);
  state_t state, state_n;
  logic [2:0] idx;
  logic [7:0] op, resp;
  logic [31:0] arg, gap;
  logic tmo, pop, exec, load, clear;
  assign tmo = state == RX && idx != '0 && gap == 32'(TIMEOUT);
  assign pop = state == RX && bus.from_uart_ready && !tmo;
  assign exec = state == EXEC;
  assign load = exec && op == OP_START;
  assign clear = exec && op == OP_STOP;
  assign bus.from_uart_read_en = pop;
  assign bus.to_uart_write_en = state == RESP && bus.to_uart_ready;
  assign bus.to_uart_data = resp;
  always_ff @(posedge clk) begin
    if (rst) state <= RX;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = pop ? GAP
            : state == GAP ? (idx == FRAME_LEN ? EXEC : RX)
            : exec ? RESP
            : bus.to_uart_write_en ? RX
            : state;
  end
  // argument bytes shift in big-endian; a full frame always replaces all four
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      op <= '0;
      arg <= '0;
      gap <= '0;
      resp <= '0;
      frame_err_cnt <= '0;
    end else begin
      gap <= (state == RX && idx != '0 && !pop && !tmo) ? gap + 32'd1 : '0;
      if (pop) begin
        idx <= idx + 3'd1;
        if (idx == '0) op <= bus.from_uart_data;
        else arg <= {arg[23:0], bus.from_uart_data};
      end
      if (tmo || exec) idx <= '0;
      if (tmo && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (exec)
        resp <= op == OP_START ? RSP_START
              : op == OP_STOP ? RSP_STOP
              : op == OP_STATUS ? {7'b0, heater_en}
              : RSP_ERR;
    end
  end
  tacc_heater_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .clear(clear),
    .arg(CNT_W'(arg)),
    .heater_en(heater_en),
    .heater_done(heater_done)
  );
endmodule

// File: tb/tb_tacc_heater_cmd.sv
// tb_tacc_heater_cmd: table-driven frame vectors plus timing, timeout, back-pressure and reset sequences
module tb_tacc_heater_cmd;
  localparam int TMO = 30;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic heater_en, heater_done;
  logic [7:0] frame_err_cnt;
  tacc_heater_cmd_if bus();
  tacc_heater_cmd #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .heater_en(heater_en),
    .heater_done(heater_done),
    .frame_err_cnt(frame_err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] op;
    logic [31:0] arg;
    logic [7:0] rsp;
    logic en;
  } vec_t;
  vec_t tbl[9];
  logic [7:0] fifo[$];
  logic [7:0] rsp_q[$];
  int cyc = 0, n_pop, heat, n_done, first_en, last_en, last_pop, done_cyc;
  int n_chk = 0, n_fail = 0;
  task automatic drive();
    bus.from_uart_ready = fifo.size() != 0;
    bus.from_uart_data = fifo.size() != 0 ? fifo[0] : 8'h00;
  endtask
  task automatic tick();
    #1;
    if (bus.from_uart_read_en) begin
      if (fifo.size() != 0) fifo.delete(0);
      n_pop++;
      last_pop = cyc;
    end
    if (bus.to_uart_write_en) rsp_q.push_back(bus.to_uart_data);
    if (heater_en) begin
      heat++;
      last_en = cyc;
      if (first_en < 0) first_en = cyc;
    end
    if (heater_done) begin
      n_done++;
      done_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic clr();
    rsp_q.delete();
    n_pop = 0;
    heat = 0;
    n_done = 0;
    first_en = -1;
    last_en = -1;
    last_pop = -1;
    done_cyc = -1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] op, input logic [31:0] arg);
    fifo.push_back(op);
    for (int i = 3; i >= 0; i--) fifo.push_back(arg[i*8 +: 8]);
    drive();
  endtask
  task automatic wait_rsp(input int want);
    int k = 0;
    while (rsp_q.size() < want && k < 200) begin
      tick();
      k++;
    end
  endtask
  function automatic int last_rsp();
    return rsp_q.size() != 0 ? int'(rsp_q[rsp_q.size()-1]) : -1;
  endfunction
  initial begin
    tbl[0] = '{8'h03, 32'h0, 8'h00, 1'b0};
    tbl[1] = '{8'h7F, 32'h0, 8'hEE, 1'b0};
    tbl[2] = '{8'h01, 32'h0, 8'hA1, 1'b0};
    tbl[3] = '{8'h01, 32'd1000, 8'hA1, 1'b1};
    tbl[4] = '{8'h03, 32'h0, 8'h01, 1'b1};
    tbl[5] = '{8'h02, 32'h0, 8'hA2, 1'b0};
    tbl[6] = '{8'h00, 32'hFFFF_FFFF, 8'hEE, 1'b0};
    tbl[7] = '{8'h03, 32'h0, 8'h00, 1'b0};
    tbl[8] = '{8'h04, 32'h12, 8'hEE, 1'b0};
    bus.to_uart_ready = 1'b1;
    drive();
    clr();
    run(3);
    chk("rst_heater_en", int'(heater_en), 0);
    chk("rst_heater_done", int'(heater_done), 0);
    chk("rst_read_en", int'(bus.from_uart_read_en), 0);
    chk("rst_write_en", int'(bus.to_uart_write_en), 0);
    chk("rst_tx_data", int'(bus.to_uart_data), 0);
    chk("rst_err_cnt", int'(frame_err_cnt), 0);
    rst = 1'b0;
    run(2);
    clr();
    for (int i = 0; i < 9; i++) begin
      rsp_q.delete();
      send(tbl[i].op, tbl[i].arg);
      wait_rsp(1);
      chk($sformatf("vec%0d_rsp", i), last_rsp(), int'(tbl[i].rsp));
      chk($sformatf("vec%0d_en", i), int'(heater_en), int'(tbl[i].en));
    end
    chk("table_no_done", n_done, 0);
    // START 10: exact duration, done timing and latency from the last pop
    clr();
    send(8'h01, 32'd10);
    run(40);
    chk("s10_rsp", last_rsp(), 'hA1);
    chk("s10_rsp_cnt", rsp_q.size(), 1);
    chk("s10_heat", heat, 10);
    chk("s10_done", n_done, 1);
    chk("s10_latency", first_en - last_pop, 3);
    chk("s10_done_pos", done_cyc - last_en, 1);
    // long START interrupted by STOP
    clr();
    send(8'h01, 32'h1000);
    wait_rsp(1);
    run(100);
    clr();
    send(8'h02, 32'h0);
    run(20);
    chk("stop_rsp", last_rsp(), 'hA2);
    chk("stop_drop", last_en - last_pop, 2);
    chk("stop_no_done", n_done, 0);
    chk("stop_en", int'(heater_en), 0);
    // partial frame times out, then alignment recovers
    clr();
    fifo.push_back(8'h01);
    fifo.push_back(8'h00);
    drive();
    run(TMO + 30);
    chk("tmo_no_rsp", rsp_q.size(), 0);
    chk("tmo_err_cnt", int'(frame_err_cnt), 1);
    send(8'h01, 32'd5);
    run(30);
    chk("tmo_next_rsp", last_rsp(), 'hA1);
    chk("tmo_next_heat", heat, 5);
    chk("tmo_next_done", n_done, 1);
    // transmit back-pressure holds RESP and stops further pops
    clr();
    bus.to_uart_ready = 1'b0;
    send(8'h03, 32'h0);
    send(8'h03, 32'h0);
    run(50);
    chk("bp_no_write", rsp_q.size(), 0);
    chk("bp_pops", n_pop, 5);
    bus.to_uart_ready = 1'b1;
    tick();
    chk("bp_one_write", rsp_q.size(), 1);
    chk("bp_rsp", last_rsp(), 'h00);
    run(30);
    chk("bp_second", rsp_q.size(), 2);
    // reset mid-run
    clr();
    send(8'h01, 32'd1000);
    wait_rsp(1);
    run(20);
    chk("mid_en", int'(heater_en), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_en", int'(heater_en), 0);
    chk("rst_mid_err", int'(frame_err_cnt), 0);
    chk("rst_mid_data", int'(bus.to_uart_data), 0);
    rst = 1'b0;
    run(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
